// File: rtl/fetch_line_unit.sv
// fetch_line_unit
//   Instruction-fetch front end in front of the direct-mapped cache. It requests
//   one 64-byte line at a time and collects the 8-beat burst into a line buffer.
//   It then hands 32-bit instructions to decode over a valid/ready handshake.
//   Sequential fall-through re-fetches at each line boundary. A branch redirect
//   can arrive in any state. A redirect during a request or a burst lets that
//   burst drain and then discards it.
//
// Ports
//   clk, reset        clock; synchronous active-high reset
//   entry             reset PC, sampled while reset is high
//   bus_reqcyc/ack    line read request handshake
//   bus_req/reqtag    line-aligned request address / read tag
//   bus_respcyc/ack   response beat handshake (ack mirrors cyc in RESP)
//   bus_resp/resptag  response beat data / tag (tag unused)
//   redirect(_pc)     branch redirect pulse and target
//   insn_valid/ready  instruction handshake toward decode
//   insn, insn_pc     instruction word and its byte address
module fetch_line_unit #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int LINE_BEATS     = 8,
    parameter int INSN_WIDTH     = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [BUS_DATA_WIDTH-1:0] entry,
    output logic                      bus_reqcyc,
    input  logic                      bus_reqack,
    output logic [BUS_DATA_WIDTH-1:0] bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    input  logic                      bus_respcyc,
    output logic                      bus_respack,
    input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    input  logic                      redirect,
    input  logic [BUS_DATA_WIDTH-1:0] redirect_pc,
    output logic                      insn_valid,
    input  logic                      insn_ready,
    output logic [INSN_WIDTH-1:0]     insn,
    output logic [BUS_DATA_WIDTH-1:0] insn_pc
);
    localparam int BEAT_BYTES = BUS_DATA_WIDTH / 8;
    localparam int LINE_BYTES = BEAT_BYTES * LINE_BEATS;
    localparam int BEAT_W     = $clog2(LINE_BEATS);
    localparam int OFF_W      = $clog2(LINE_BYTES);
    localparam int BOFF_W     = $clog2(BEAT_BYTES);
    localparam int IOFF_W     = $clog2(INSN_WIDTH / 8);

    localparam logic [BUS_TAG_WIDTH-1:0]  READ_TAG  = {1'b1, {(BUS_TAG_WIDTH-1){1'b0}}};
    localparam logic [BEAT_W-1:0]         LAST_BEAT = BEAT_W'(LINE_BEATS - 1);
    localparam logic [BUS_DATA_WIDTH-1:0] INSN_STEP = BUS_DATA_WIDTH'(INSN_WIDTH / 8);

    typedef enum logic [1:0] {S_REQ, S_RESP, S_DELIVER} state_t;

    function automatic logic [BUS_DATA_WIDTH-1:0] align_insn(input logic [BUS_DATA_WIDTH-1:0] a);
        return {a[BUS_DATA_WIDTH-1:IOFF_W], {IOFF_W{1'b0}}};
    endfunction

    function automatic logic [BUS_DATA_WIDTH-1:0] align_line(input logic [BUS_DATA_WIDTH-1:0] a);
        return {a[BUS_DATA_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
    endfunction

    state_t                    state_q, state_d;
    logic [BUS_DATA_WIDTH-1:0] pc_q, pc_d;
    logic [BUS_DATA_WIDTH-1:0] reqaddr_q, reqaddr_d;
    logic [BEAT_W-1:0]         beat_q, beat_d;
    logic                      discard_q, discard_d;
    logic                      started_q;
    logic                      line_we;
    logic [BUS_DATA_WIDTH-1:0] line_q [LINE_BEATS];
    logic [BUS_DATA_WIDTH-1:0] beat_word;

    logic unused_inputs;
    assign unused_inputs = ^{bus_resptag, entry[IOFF_W-1:0], redirect_pc[IOFF_W-1:0]};

    assign beat_word = line_q[pc_q[OFF_W-1:BOFF_W]];

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        beat_d      = beat_q;
        discard_d   = discard_q;
        reqaddr_d   = reqaddr_q;
        line_we     = 1'b0;
        bus_reqcyc  = 1'b0;
        bus_req     = '0;
        bus_reqtag  = '0;
        bus_respack = 1'b0;
        insn_valid  = 1'b0;
        insn        = '0;
        insn_pc     = '0;

        if (reset) begin
            // Outputs forced low; the register block reloads everything.
        end else if (!started_q) begin
            // One quiet cycle after reset before the first request goes out.
            if (redirect) pc_d = align_insn(redirect_pc);
        end else begin
            unique case (state_q)
                S_REQ: begin
                    bus_reqcyc = 1'b1;
                    bus_req    = reqaddr_q;
                    bus_reqtag = READ_TAG;
                    // The presented address stays put; the new target is
                    // fetched after this burst drains.
                    if (redirect) begin
                        pc_d      = align_insn(redirect_pc);
                        discard_d = 1'b1;
                    end
                    if (bus_reqack) begin
                        state_d = S_RESP;
                        beat_d  = '0;
                    end
                end
                S_RESP: begin
                    bus_respack = bus_respcyc;
                    if (redirect) begin
                        pc_d      = align_insn(redirect_pc);
                        discard_d = 1'b1;
                    end
                    if (bus_respcyc) begin
                        line_we = 1'b1;
                        beat_d  = beat_q + BEAT_W'(1);
                        if (beat_q == LAST_BEAT) begin
                            beat_d = '0;
                            if (discard_q || redirect) begin
                                state_d   = S_REQ;
                                discard_d = 1'b0;
                            end else begin
                                state_d = S_DELIVER;
                            end
                        end
                    end
                end
                S_DELIVER: begin
                    insn_valid = 1'b1;
                    insn_pc    = pc_q;
                    insn       = beat_word[int'(pc_q[BOFF_W-1:IOFF_W]) * INSN_WIDTH +: INSN_WIDTH];
                    // Redirect wins over the sequential increment even when
                    // the current instruction is consumed this cycle.
                    if (redirect) begin
                        pc_d    = align_insn(redirect_pc);
                        state_d = S_REQ;
                    end else if (insn_ready) begin
                        pc_d = pc_q + INSN_STEP;
                        if (&pc_q[OFF_W-1:IOFF_W]) state_d = S_REQ;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end

        // Latch a fresh request address only when a request is not already
        // on the bus, so a stalled request never changes under the cache.
        if (state_d == S_REQ && !(started_q && state_q == S_REQ)) begin
            reqaddr_d = align_line(pc_d);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_REQ;
            pc_q      <= align_insn(entry);
            reqaddr_q <= align_line(entry);
            beat_q    <= '0;
            discard_q <= 1'b0;
            started_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            reqaddr_q <= reqaddr_d;
            beat_q    <= beat_d;
            discard_q <= discard_d;
            started_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (line_we) line_q[beat_q] <= bus_resp;
    end

endmodule

// File: doc/fetch_line_unit.md
Name: fetch_line_unit

Overview:
- Instruction-fetch front end sitting directly upstream of the direct-mapped cache on the processor-side bus.
- Issues 64-byte line read requests, collects the 8-beat response into a line buffer, and hands 32-bit instructions one at a time to decode over a valid/ready interface.
- Handles sequential fall-through and branch redirects, including a redirect that arrives while a burst is in flight.

Parameters:
BUS_DATA_WIDTH, 64, processor-side bus data/address width
BUS_TAG_WIDTH, 13, bus tag width; bit 12 = 1 marks a read
LINE_BEATS, 8, beats per cache line (64 bytes)
INSN_WIDTH, 32, instruction width

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- entry  input  64  reset PC, sampled while reset=1
- bus_reqcyc  output  1  line request valid
- bus_reqack  input  1  cache accepted request
- bus_req  output  64  line-aligned request address
- bus_reqtag  output  13  request tag
- bus_respcyc  input  1  response beat valid
- bus_respack  output  1  beat accepted
- bus_resp  input  64  response beat data
- bus_resptag  input  13  response tag (ignored)
- redirect  input  1  branch redirect pulse
- redirect_pc  input  64  redirect target
- insn_valid  output  1  instruction available
- insn_ready  input  1  decode accepts
- insn  output  32  instruction
- insn_pc  output  64  address of insn

Behaviour:
- Reset: clk and reset are already decided (reset synchronous, active-high; clock clk). While reset=1: pc<=entry, state<=REQ, beat<=0, discard<=0. All outputs are 0 during reset and in the cycle after reset deasserts, except that bus_reqcyc rises 1 cycle after reset deasserts. Reset mid-burst abandons the burst with no drain.
- pc is a register of byte address, 4-byte aligned; pc[1:0] is forced to 0.
- REQ:
  - bus_reqcyc=1, bus_req={pc[63:6],6'b0}, bus_reqtag=13'h1000.
  - Address and tag are held stable until bus_reqack=1; then go to RESP with beat=0.
  - A redirect during REQ updates pc and sets discard=1. The already-presented address is NOT changed.
- RESP:
  - bus_respack=bus_respcyc, combinational, same cycle.
  - Each accepted beat writes line[beat]=bus_resp and increments beat.
  - On the 8th beat (beat==7): if discard=1 or a redirect occurs that cycle, go to REQ (discard<=0). Otherwise go to DELIVER.
  - A redirect in RESP updates pc and sets discard. The burst is always drained fully.
- DELIVER:
  - insn_valid=1; insn_pc=pc; insn = line[pc[5:3]] bits [31:0] if pc[2]=0, else bits [63:32] (little-endian).
  - Handshake on insn_valid&insn_ready: pc<=pc+4.
  - If the new pc crosses the line boundary (old pc[5:2]==15), go to REQ next cycle.
  - insn and insn_pc stay stable while valid and not ready.
- Redirect in DELIVER: pc<=redirect_pc, go to REQ, insn_valid=0 from the next cycle. A handshake in the same cycle still counts as consumed; redirect wins over pc+4.
- Simultaneous redirects across cycles: the last one wins.
- Redirect to the same line always re-fetches; there is no line reuse.
- Latency: redirect to first insn_valid is at least 1 (REQ) + ack wait + 8 beats + 1 cycle. Sequential line crossing incurs the same bubble.
- No write requests are ever issued; bus_reqtag[12] is always 1.

Test Plan:
1. entry=0x1000; cache acks the first cycle and returns beats 0..7 = 0x0000000B_0000000A, 0x..D_..C, ... -> bus_req=0x1000. Then insn sequence 0xA@0x1000, 0xB@0x1004, 0xC@0x1008 ... 16 insns. Then a new request to 0x1040.
2. entry=0x1038 -> request 0x1000; first insn is line[7][31:0] @0x1038, second is [63:32] @0x103C, then request 0x1040.
3. insn_ready held 0 for 5 cycles in DELIVER -> insn/insn_pc unchanged, pc does not advance.
4. Redirect to 0x2000 at beat 3 of a burst -> beats 4..7 still acked, no insn_valid. Next request is 0x2000, first insn_pc=0x2000.
5. Redirect to 0x3004 while REQ is stalled (reqack=0 for 4 cycles) -> bus_req stays the old line until ack, that burst is discarded, then request 0x3000, first insn_pc=0x3004.
6. Redirect coinciding with an insn handshake -> next insn_pc is redirect_pc. Reset asserted mid-burst -> all outputs 0, restart from entry.
